ipf_lcu_sched: RTL and testbench
================================

Name: ipf_lcu_sched

Overview:
Scheduler that feeds the IPF filter datapath one LCU at a time for a 128x128, 8-bit image. It reads pixels from image memory and per-LCU filter parameters from a parameter memory. Pixels stream to the filter in raster order inside each LCU; LCUs are visited in raster order. It handles filter back-pressure (busy), switches parameters at LCU boundaries, then waits for the filter's finish before reporting done.

Parameters:
IMG_LOG, 7, log2 of image width/height (128)
PAR_W, 24, packed parameter word width {type[23:22], band_pos[21:17], wo_class[16], offset[15:0]}

Ports:
clk  in  1  clock, single domain
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse; begins a frame when idle
cfg_lcu_size  in  2  0=16, 1=32, 2=64 (3 illegal, treated as 0); held stable for the frame
img_rd_en  out  1  image memory read strobe
img_addr  out  14  {pix_y[6:0], pix_x[6:0]}
img_rdata  in  8  pixel; valid the cycle after img_rd_en
par_rd_en  out  1  parameter memory read strobe
par_addr  out  6  LCU index = lcu_y*LPR + lcu_x, where LPR = 128>>(4+cfg_lcu_size)
par_rdata  in  24  packed parameters; valid the cycle after par_rd_en
busy  in  1  filter back-pressure; no pixel is accepted while high
finish  in  1  filter end-of-image flag
in_en  out  1  pixel valid to filter
din  out  8  pixel to filter
ipf_type  out  2  filter type for the current LCU
ipf_band_pos  out  5  band position for the current LCU
ipf_wo_class  out  1  WO class (0=H, 1=V) for the current LCU
ipf_offset  out  16  offsets for the current LCU
lcu_x  out  3  LCU column for the current LCU
lcu_y  out  3  LCU row for the current LCU
lcu_size  out  2  registered copy of cfg_lcu_size
done  out  1  one-cycle pulse when the frame is complete

Behaviour:
- Reset: all outputs 0; state IDLE; counters, hold register and shadow register cleared. Reset mid-frame aborts immediately with no drain.
- States: IDLE, PFETCH, PLOAD, STREAM, DRAIN, WFIN, DONE.
- IDLE: start=1 -> PFETCH. start outside IDLE is ignored.
- PFETCH (1 cycle): par_rd_en=1, par_addr=0 -> PLOAD.
- PLOAD (1 cycle): par_rdata -> ipf_* outputs; lcu_x=lcu_y=0; lcu_size latched -> STREAM.
- Latency: start at cycle 0 -> first img_rd_en at cycle 3 -> first in_en at cycle 4, with busy=0 throughout.
- STREAM issue rule:
  - Read issued when busy=0 and the hold register is empty.
  - Address from counters: col, row (0..N-1), lx, ly.
  - pix_x = lx*N + col, pix_y = ly*N + row.
  - col wraps to 0 at N-1 and increments row; the LCU advances after (N-1, N-1); lx wraps at LPR-1 and increments ly.
- Delivery:
  - The cycle after a read, if busy=0: in_en=1, din=img_rdata.
  - If busy=1: the pixel goes to a 1-entry hold register, in_en=0. It is presented on the first cycle busy=0, and no new read is issued that cycle.
  - Every pixel is presented exactly once and in order.
- Parameter prefetch:
  - On the issue of pixel (0,0) of LCU k (k below the last), par_rd_en reads LCU k+1. Its data is captured into a shadow register the next cycle.
- Parameter switch:
  - ipf_*, lcu_x and lcu_y change to the LCU k+1 values on the clock edge after the last pixel of LCU k is presented (in_en=1).
  - They are stable throughout LCU k+1's pixels.
- After issuing the last pixel of the frame -> DRAIN. DRAIN waits until that pixel is presented -> WFIN.
- WFIN: waits for finish=1 (any cycle, including the same cycle as entry) -> DONE.
- DONE: done=1 for 1 cycle -> IDLE. ipf_* outputs hold their last values.
- in_en is never asserted while busy=1 and never asserted outside STREAM/DRAIN.

Decomposition:
- Shared package ipf_pkg holds:
  - state enum
  - LCU-size encodings
  - parameter-word field offsets (TYPE_MSB, BAND_MSB, CLASS_BIT, OFF_MSB)
  - function lpr(size)
- One natural sub-module, ipf_lcu_addr_gen: col/row/lx/ly counters with an advance input. It outputs img_addr, par_addr, last_in_lcu and last_in_frame.

Test Plan:
- lcu_size=0, busy=0, image pattern pix[addr]=addr[7:0], param[i]={2'd1,5'(i),1'b0,16'h1234}, finish tied 1:
  - first in_en at cycle 4 after start
  - 16384 in_en pulses
  - pulse 17 carries addr {7'd1,7'd0} -> din=0x80
  - done 1 cycle after the last pixel plus WFIN/DONE.
- lcu_size=2: 4 LCUs.
  - par_addr sequence 0,1,2,3.
  - The pixel after (x=63, y=63) is (x=64, y=0).
  - lcu_x/lcu_y sequence (0,0),(1,0),(0,1),(1,1), each switching the edge after its predecessor's 4096th pixel.
- busy high for cycles 10-14 and on alternate cycles for 100 cycles:
  - din sequence identical to the busy=0 run
  - no duplicates or drops
  - in_en=0 whenever busy=1.
- finish held 0 for 50 cycles after the last pixel:
  - state stays WFIN
  - finish=1 -> done pulses exactly once, next cycle after DONE.
- reset asserted mid-STREAM at pixel 300:
  - all outputs 0 next cycle
  - new start restarts from addr 0 and param 0.
- start pulsed during STREAM: ignored; pixel count and order are unchanged.

Source files
------------

// File: rtl/ipf_lcu_sched_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipf_pkg: shared states, LCU-size encodings and parameter-word layout.
// Revision: 1.0
// ----------------------------------------------------------------------------
package ipf_pkg;

  localparam int IMG_LOG = 7;
  localparam int PAR_W   = 24;

  typedef logic [2:0] state_t;
  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_PFETCH = 3'd1;
  localparam state_t S_PLOAD  = 3'd2;
  localparam state_t S_STREAM = 3'd3;
  localparam state_t S_DRAIN  = 3'd4;
  localparam state_t S_WFIN   = 3'd5;
  localparam state_t S_DONE   = 3'd6;

  localparam logic [1:0] LCU_16 = 2'd0;
  localparam logic [1:0] LCU_32 = 2'd1;
  localparam logic [1:0] LCU_64 = 2'd2;

  localparam int TYPE_MSB  = 23;
  localparam int BAND_MSB  = 21;
  localparam int CLASS_BIT = 16;
  localparam int OFF_MSB   = 15;

  // The reserved encoding behaves as the smallest LCU.
  function automatic logic [1:0] norm_size(input logic [1:0] s);
    return (s == LCU_32 || s == LCU_64) ? s : LCU_16;
  endfunction

  function automatic logic [3:0] lpr(input logic [1:0] size);
    case (norm_size(size))
      LCU_32:  return 4'd4;
      LCU_64:  return 4'd2;
      default: return 4'd8;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ipf_lcu_sched_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipf_lcu_sched_if: memory, filter and control signals of the LCU scheduler.
// Revision: 1.0
// ----------------------------------------------------------------------------
interface ipf_lcu_sched_if;
  import ipf_pkg::*;

  logic                   start;
  logic [1:0]             cfg_lcu_size;
  logic                   img_rd_en;
  logic [2*IMG_LOG-1:0]   img_addr;
  logic [7:0]             img_rdata;
  logic                   par_rd_en;
  logic [5:0]             par_addr;
  logic [PAR_W-1:0]       par_rdata;
  logic                   busy;
  logic                   finish;
  logic                   in_en;
  logic [7:0]             din;
  logic [1:0]             ipf_type;
  logic [4:0]             ipf_band_pos;
  logic                   ipf_wo_class;
  logic [15:0]            ipf_offset;
  logic [2:0]             lcu_x;
  logic [2:0]             lcu_y;
  logic [1:0]             lcu_size;
  logic                   done;

  modport master (
    input  start, cfg_lcu_size, img_rdata, par_rdata, busy, finish,
    output img_rd_en, img_addr, par_rd_en, par_addr, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );

  modport slave (
    output start, cfg_lcu_size, img_rdata, par_rdata, busy, finish,
    input  img_rd_en, img_addr, par_rd_en, par_addr, in_en, din,
           ipf_type, ipf_band_pos, ipf_wo_class, ipf_offset,
           lcu_x, lcu_y, lcu_size, done
  );

endinterface
`default_nettype wire

// File: rtl/ipf_lcu_sched_addr_gen.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipf_lcu_addr_gen: col/row/LCU counters producing pixel and parameter addresses.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ipf_lcu_addr_gen
  import ipf_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 advance,
  input  logic [1:0]           size,
  output logic [2*IMG_LOG-1:0] img_addr,
  output logic [5:0]           par_addr,
  output logic                 first_in_lcu,
  output logic                 last_in_lcu,
  output logic                 last_lcu,
  output logic                 last_in_frame
);

  logic [5:0]         col_q, col_d, row_q, row_d;
  logic [2:0]         lx_q, lx_d, ly_q, ly_d;
  logic [2:0]         n_log;
  logic [5:0]         n_max;
  logic [2:0]         lpr_max;
  logic [IMG_LOG-1:0] pix_x, pix_y;
  logic [5:0]         lcu_idx;

  always_comb begin
    n_log   = 3'd4 + {1'b0, size};
    n_max   = 6'((7'd1 << n_log) - 7'd1);
    lpr_max = 3'(lpr(size) - 4'd1);

    // N and LPR are powers of two and col/lx never reach them, so OR acts as add.
    pix_x   = ({4'd0, lx_q} << n_log) | {1'b0, col_q};
    pix_y   = ({4'd0, ly_q} << n_log) | {1'b0, row_q};
    lcu_idx = ({3'd0, ly_q} << (2'd3 - size)) | {3'd0, lx_q};

    img_addr      = {pix_y, pix_x};
    par_addr      = lcu_idx + 6'd1;
    first_in_lcu  = (col_q == 6'd0) && (row_q == 6'd0);
    last_in_lcu   = (col_q == n_max) && (row_q == n_max);
    last_lcu      = (lx_q == lpr_max) && (ly_q == lpr_max);
    last_in_frame = last_in_lcu && last_lcu;

    col_d = col_q;
    row_d = row_q;
    lx_d  = lx_q;
    ly_d  = ly_q;
    if (clear) begin
      col_d = 6'd0;
      row_d = 6'd0;
      lx_d  = 3'd0;
      ly_d  = 3'd0;
    end else if (advance) begin
      if (col_q != n_max) begin
        col_d = col_q + 6'd1;
      end else begin
        col_d = 6'd0;
        if (row_q != n_max) begin
          row_d = row_q + 6'd1;
        end else begin
          row_d = 6'd0;
          if (lx_q != lpr_max) begin
            lx_d = lx_q + 3'd1;
          end else begin
            lx_d = 3'd0;
            ly_d = (ly_q == lpr_max) ? 3'd0 : ly_q + 3'd1;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= 6'd0;
      row_q <= 6'd0;
      lx_q  <= 3'd0;
      ly_q  <= 3'd0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      lx_q  <= lx_d;
      ly_q  <= ly_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/ipf_lcu_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// ipf_lcu_sched: streams a 128x128 image to the IPF filter LCU by LCU.
// Revision: 1.0
// ----------------------------------------------------------------------------
module ipf_lcu_sched
  import ipf_pkg::*;
(
  input  logic            clk,
  input  logic            reset,
  ipf_lcu_sched_if.master bus
);

  state_t             state_q, state_d;
  logic               rd_pend_q, rd_pend_d;
  logic               rd_lcu_end_q, rd_lcu_end_d, rd_frm_end_q, rd_frm_end_d;
  logic               hold_vld_q, hold_vld_d;
  logic               hold_lcu_end_q, hold_lcu_end_d, hold_frm_end_q, hold_frm_end_d;
  logic [7:0]         hold_pix_q, hold_pix_d;
  logic               par_pend_q, par_pend_d;
  logic [PAR_W-1:0]   shadow_q, shadow_d, par_q, par_d;
  logic [2:0]         lcu_x_q, lcu_x_d, lcu_y_q, lcu_y_d;
  logic [1:0]         size_q, size_d;

  logic               issue, present, pres_lcu_end, pres_frm_end, prefetch, gen_clear;
  logic [2:0]         lpr_max;
  logic [2*IMG_LOG-1:0] gen_img_addr;
  logic [5:0]         gen_par_addr;
  logic               first_in_lcu, last_in_lcu, last_lcu, last_in_frame;

  ipf_lcu_addr_gen u_addr_gen (
    .clk           (clk),
    .reset         (reset),
    .clear         (gen_clear),
    .advance       (issue),
    .size          (size_q),
    .img_addr      (gen_img_addr),
    .par_addr      (gen_par_addr),
    .first_in_lcu  (first_in_lcu),
    .last_in_lcu   (last_in_lcu),
    .last_lcu      (last_lcu),
    .last_in_frame (last_in_frame)
  );

  always_comb begin
    gen_clear    = (state_q == S_PLOAD);
    issue        = (state_q == S_STREAM) && !bus.busy && !hold_vld_q;
    // At most one of rd_pend/hold_vld is set, so a single pixel is ever in flight.
    present      = (hold_vld_q || rd_pend_q) && !bus.busy;
    pres_lcu_end = hold_vld_q ? hold_lcu_end_q : rd_lcu_end_q;
    pres_frm_end = hold_vld_q ? hold_frm_end_q : rd_frm_end_q;
    prefetch     = issue && first_in_lcu && !last_lcu;
    lpr_max      = 3'(lpr(size_q) - 4'd1);

    state_d        = state_q;
    rd_pend_d      = issue;
    rd_lcu_end_d   = issue && last_in_lcu;
    rd_frm_end_d   = issue && last_in_frame;
    hold_vld_d     = hold_vld_q;
    hold_pix_d     = hold_pix_q;
    hold_lcu_end_d = hold_lcu_end_q;
    hold_frm_end_d = hold_frm_end_q;
    par_pend_d     = prefetch;
    shadow_d       = shadow_q;
    par_d          = par_q;
    lcu_x_d        = lcu_x_q;
    lcu_y_d        = lcu_y_q;
    size_d         = size_q;

    if (rd_pend_q && bus.busy) begin
      hold_vld_d     = 1'b1;
      hold_pix_d     = bus.img_rdata;
      hold_lcu_end_d = rd_lcu_end_q;
      hold_frm_end_d = rd_frm_end_q;
    end else if (hold_vld_q && !bus.busy) begin
      hold_vld_d = 1'b0;
    end

    if (par_pend_q) begin
      shadow_d = bus.par_rdata;
    end

    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_PFETCH;
      S_PFETCH: state_d = S_PLOAD;
      S_PLOAD: begin
        par_d   = bus.par_rdata;
        lcu_x_d = 3'd0;
        lcu_y_d = 3'd0;
        size_d  = norm_size(bus.cfg_lcu_size);
        state_d = S_STREAM;
      end
      S_STREAM: if (issue && last_in_frame) state_d = S_DRAIN;
      S_DRAIN:  if (present && pres_frm_end) state_d = S_WFIN;
      S_WFIN:   if (bus.finish) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase

    // Parameters for the next LCU take effect right after its predecessor's last pixel.
    if (present && pres_lcu_end && !pres_frm_end) begin
      par_d = shadow_q;
      if (lcu_x_q == lpr_max) begin
        lcu_x_d = 3'd0;
        lcu_y_d = lcu_y_q + 3'd1;
      end else begin
        lcu_x_d = lcu_x_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= S_IDLE;
      rd_pend_q      <= 1'b0;
      rd_lcu_end_q   <= 1'b0;
      rd_frm_end_q   <= 1'b0;
      hold_vld_q     <= 1'b0;
      hold_pix_q     <= 8'd0;
      hold_lcu_end_q <= 1'b0;
      hold_frm_end_q <= 1'b0;
      par_pend_q     <= 1'b0;
      shadow_q       <= '0;
      par_q          <= '0;
      lcu_x_q        <= 3'd0;
      lcu_y_q        <= 3'd0;
      size_q         <= 2'd0;
    end else begin
      state_q        <= state_d;
      rd_pend_q      <= rd_pend_d;
      rd_lcu_end_q   <= rd_lcu_end_d;
      rd_frm_end_q   <= rd_frm_end_d;
      hold_vld_q     <= hold_vld_d;
      hold_pix_q     <= hold_pix_d;
      hold_lcu_end_q <= hold_lcu_end_d;
      hold_frm_end_q <= hold_frm_end_d;
      par_pend_q     <= par_pend_d;
      shadow_q       <= shadow_d;
      par_q          <= par_d;
      lcu_x_q        <= lcu_x_d;
      lcu_y_q        <= lcu_y_d;
      size_q         <= size_d;
    end
  end

  assign bus.img_rd_en    = issue;
  assign bus.img_addr     = gen_img_addr;
  assign bus.par_rd_en    = (state_q == S_PFETCH) || prefetch;
  assign bus.par_addr     = prefetch ? gen_par_addr : 6'd0;
  assign bus.in_en        = present;
  assign bus.din          = !present ? 8'd0 : (hold_vld_q ? hold_pix_q : bus.img_rdata);
  assign bus.ipf_type     = par_q[TYPE_MSB -: 2];
  assign bus.ipf_band_pos = par_q[BAND_MSB -: 5];
  assign bus.ipf_wo_class = par_q[CLASS_BIT];
  assign bus.ipf_offset   = par_q[OFF_MSB:0];
  assign bus.lcu_x        = lcu_x_q;
  assign bus.lcu_y        = lcu_y_q;
  assign bus.lcu_size     = size_q;
  assign bus.done         = (state_q == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_ipf_lcu_sched.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_ipf_lcu_sched: frame-level bench with memory models and a pixel-order reference.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_ipf_lcu_sched;

  logic clk;
  logic reset;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   d17     = 0;

  logic [7:0]  img_mem [0:16383];
  logic [23:0] par_mem [0:63];
  logic [7:0]  img_q;
  logic [23:0] par_q;

  ipf_lcu_sched_if bus ();

  ipf_lcu_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous-read memories; data is garbage on cycles without a read.
  always @(posedge clk) begin
    img_q <= bus.img_rd_en ? img_mem[bus.img_addr] : 8'($urandom);
    par_q <= bus.par_rd_en ? par_mem[bus.par_addr] : 24'($urandom);
  end
  assign bus.img_rdata = img_q;
  assign bus.par_rdata = par_q;

  task automatic chk_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] all_outs();
    return {bus.img_rd_en, bus.img_addr, bus.par_rd_en, bus.par_addr, bus.in_en, bus.din,
            bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset,
            bus.lcu_x, bus.lcu_y, bus.lcu_size, bus.done};
  endfunction

  function automatic logic [23:0] cur_params();
    return {bus.ipf_type, bus.ipf_band_pos, bus.ipf_wo_class, bus.ipf_offset};
  endfunction

  function automatic logic busy_fn(input int mode, input int c);
    case (mode)
      1:       return (c >= 10 && c <= 14) || (c >= 20 && c < 120 && (c % 2) == 1) ||
                      (c >= 120 && $urandom_range(7) == 0);
      2:       return $urandom_range(3) == 0;
      default: return 1'b0;
    endcase
  endfunction

  task automatic fill(input bit pattern);
    for (int i = 0; i < 16384; i++) img_mem[i] = pattern ? 8'(i) : 8'($urandom);
    for (int i = 0; i < 64; i++)
      par_mem[i] = pattern ? {2'd1, 5'(i), 1'b0, 16'h1234} : 24'($urandom);
  endtask

  // One frame: reference pixel order is LCU raster, then raster inside each LCU.
  task automatic run_frame(input int size, input int bmode, input int fin_wait,
                           input int restart_at, input int abort_at, input bit chk_lat);
    logic [13:0] qa[$];
    int          ql[$];
    logic [13:0] a;
    int n, lpr_n, nl, cyc, npix, t_first, t_last, t_done, pidx, l;

    n = 16 << size;
    lpr_n = 8 >> size;
    nl = lpr_n * lpr_n;
    for (int ly = 0; ly < lpr_n; ly++)
      for (int lx = 0; lx < lpr_n; lx++)
        for (int row = 0; row < n; row++)
          for (int col = 0; col < n; col++) begin
            qa.push_back({7'(ly * n + row), 7'(lx * n + col)});
            ql.push_back(ly * lpr_n + lx);
          end

    cyc = 0; npix = 0; t_first = -1; t_last = -1; t_done = -1; pidx = 0;
    @(posedge clk); #1;
    bus.cfg_lcu_size = 2'(size);
    bus.start  = 1'b1;
    bus.busy   = 1'b0;
    bus.finish = (fin_wait == 0);

    while (cyc < 40000) begin
      @(negedge clk);
      if (bus.busy) chk_eq("in_en_while_busy", bus.in_en, 0);
      if (bus.par_rd_en) begin
        chk_eq("par_addr", bus.par_addr, pidx);
        pidx++;
      end
      if (bus.in_en) begin
        if (npix == 0) t_first = cyc;
        if (qa.size() == 0) begin
          chk_eq("extra_pixel", 1, 0);
        end else begin
          a = qa.pop_front();
          l = ql.pop_front();
          chk_eq("din", bus.din, img_mem[a]);
          chk_eq("params", cur_params(), par_mem[l]);
          chk_eq("lcu_xy", {bus.lcu_y, bus.lcu_x}, {3'(l / lpr_n), 3'(l % lpr_n)});
        end
        npix++;
        t_last = cyc;
        if (npix == 1) chk_eq("lcu_size", bus.lcu_size, size);
        if (npix == 17) d17 = int'(bus.din);
      end
      if (bus.done) begin
        t_done = cyc;
        break;
      end
      if (abort_at > 0 && npix == abort_at) break;
      @(posedge clk); #1;
      cyc++;
      bus.start  = (cyc == restart_at);
      bus.busy   = busy_fn(bmode, cyc);
      bus.finish = (fin_wait == 0) || (npix == 16384 && cyc > t_last + fin_wait);
    end

    if (abort_at > 0) begin
      chk_eq("abort_reached", npix, abort_at);
      @(posedge clk); #1;
      reset = 1'b1; bus.start = 1'b0; bus.busy = 1'b0;
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk_eq("outs_after_reset", all_outs(), 64'd0);
      return;
    end

    chk_eq("done_seen", t_done >= 0, 1);
    chk_eq("pixel_count", npix, 16384);
    chk_eq("par_read_count", pidx, nl);
    chk_eq("done_latency", t_done - t_last, fin_wait + 2);
    if (chk_lat) chk_eq("first_in_en_cycle", t_first, 4);
    repeat (3) begin
      @(posedge clk); #1;
      bus.start = 1'b0; bus.busy = 1'b0;
      @(negedge clk);
      chk_eq("done_once", bus.done, 0);
      chk_eq("idle_in_en", bus.in_en, 0);
    end
    chk_eq("params_hold", cur_params(), par_mem[nl-1]);
  endtask

  initial begin
    reset = 1'b1;
    bus.start = 1'b0; bus.busy = 1'b0; bus.finish = 1'b0; bus.cfg_lcu_size = 2'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk_eq("reset_outs", all_outs(), 64'd0);

    fill(1'b1);
    run_frame(0, 0, 0, 1000, 0, 1'b1);
    chk_eq("pulse17_din", d17, 8'h80);

    fill(1'b0);
    run_frame(2, 1, 50, 0, 0, 1'b1);
    run_frame(1, 0, 0, 0, 300, 1'b1);
    run_frame(1, 2, 0, 0, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
